rr_stream_arbiter: RTL and testbench



---
 rtl/rr_stream_arbiter_pkg.sv | 21 ++
 rtl/rr_stream_arbiter_if.sv | 45 ++++
 rtl/rr_stream_arbiter_pick.sv | 45 ++++
 rtl/rr_stream_arbiter.sv | 99 +++++++++
 tb/tb_rr_stream_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rr_stream_arbiter_pkg.sv
// Shared definitions for the round-robin stream arbiter: size defaults,
// ID width helper and the packet-lock state type.
// No ports; imported by rr_pick, rr_stream_arbiter_if and rr_stream_arbiter.
package rr_stream_arbiter_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Bundle of requester-side and downstream-side handshake signals.
// Ports: req_valid/req_ready/req_data (N streams), out_valid/out_ready/out_data/out_id.
// Optional req_last (packet-end marker) exists only with RR_STREAM_ARBITER_LOCK_EN.
interface rr_stream_arbiter_if
  import rr_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
`ifdef RR_STREAM_ARBITER_LOCK_EN
  logic [NUM_REQ-1:0]            req_last;
`endif
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [ID_WIDTH-1:0]           out_id;

`ifdef RR_STREAM_ARBITER_LOCK_EN
  // Arbiter view.
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
  // Environment view (requesters plus downstream consumer).
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
`else
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
`endif

endinterface

// File: rtl/rr_stream_arbiter_pick.sv
// Combinational round-robin priority search starting at rr_ptr.
// Latency: 0 cycles. Backpressure: none, pure function of req and rr_ptr.
// Ports: req (valid vector), rr_ptr (search start) -> grant (one-hot), idx, any_valid.
module rr_pick
  import rr_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any_valid
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0]   rot_req;
  logic [ID_WIDTH-1:0]  offset;
  logic [ID_WIDTH:0]    sum;

  always_comb begin
    // Doubling the vector turns the wrap-around into a plain right shift:
    // bit k of rot_req is requester (rr_ptr + k) mod NUM_REQ.
    dbl       = {req, req};
    rot       = dbl >> rr_ptr;
    rot_req   = rot[NUM_REQ-1:0];
    any_valid = 1'b0;
    offset    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && rot_req[k]) begin
        any_valid = 1'b1;
        offset    = ID_WIDTH'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
      sum = sum - (ID_WIDTH+1)'(NUM_REQ);
    end
    idx   = any_valid ? sum[ID_WIDTH-1:0] : '0;
    grant = any_valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_stream_arbiter.sv
// N-to-1 round-robin arbiter feeding one registered valid/ready output stage.
// Latency: 1 cycle from requester handshake to out_valid; full throughput.
// Backpressure: req_ready is all-zero while the stage is full and out_ready=0.
// Ports: clk, rst (sync, active-high), bus (rr_stream_arbiter_if.slave).
// Optional RR_STREAM_ARBITER_LOCK_EN: req_last holds the grant on one
// requester until its packet-end beat.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_stream_arbiter_if.slave   bus
);

  localparam int ID_WIDTH = id_width(NUM_REQ);

  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   win_idx;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic [NUM_REQ-1:0]    pick_req;
  logic [NUM_REQ-1:0]    grant;
  logic                  any_valid;
  logic                  can_accept;
  logic                  handshake;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ID_WIDTH-1:0]   out_id_q;

`ifdef RR_STREAM_ARBITER_LOCK_EN
  lock_state_t           lock_state;
  logic [ID_WIDTH-1:0]   lock_id;

  // While locked, only the owning requester is visible to the search, so the
  // grant stays put even if that requester is momentarily idle.
  always_comb begin
    pick_req = bus.req_valid;
    if (lock_state == LOCKED) begin
      pick_req = bus.req_valid & (NUM_REQ'(1) << lock_id);
    end
  end
`else
  assign pick_req = bus.req_valid;
`endif

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req       (pick_req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .idx       (win_idx),
    .any_valid (any_valid)
  );

  assign can_accept    = ~out_valid_q | bus.out_ready;
  assign bus.req_ready = (rst || !can_accept) ? '0 : grant;
  assign handshake     = any_valid & can_accept & ~rst;
  assign next_ptr      = (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr      <= '0;
`ifdef RR_STREAM_ARBITER_LOCK_EN
      lock_state  <= UNLOCKED;
      lock_id     <= '0;
`endif
    end else if (handshake) begin
      // A new beat overwrites a draining one, so back-to-back has no bubble.
      out_valid_q <= 1'b1;
      out_data_q  <= bus.req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      out_id_q    <= win_idx;
`ifdef RR_STREAM_ARBITER_LOCK_EN
      if (bus.req_last[win_idx]) begin
        lock_state <= UNLOCKED;
        rr_ptr     <= next_ptr;
      end else begin
        lock_state <= LOCKED;
        lock_id    <= win_idx;
      end
`else
      rr_ptr      <= next_ptr;
`endif
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Randomized scoreboard bench for rr_stream_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// A reference model predicts grants and pushes expected beats; a monitor
// pops and compares whenever a beat leaves the output stage.
module tb_rr_stream_arbiter;
  import rr_stream_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = id_width(N);

  typedef struct {
    int           id;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_stream_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  rr_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: requester contents and arbiter abstraction.
  bit            v [N];
  logic [DW-1:0] d [N];
  bit            l [N];
  int            m_ptr    = 0;
  bit            m_full   = 0;
  bit            m_locked = 0;
  int            m_lock_id = 0;
  beat_t         sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_winner();
    if (m_locked) return v[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = v[i];
      bus.req_data[i*DW +: DW]   = d[i];
`ifdef RR_STREAM_ARBITER_LOCK_EN
      bus.req_last[i]            = l[i];
`endif
    end
  endtask

  // Monitor: pops on every completed output transfer, and checks that a
  // stalled beat is held unchanged.
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_id;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && bus.out_valid) begin
          check("hold_data", 32'(bus.out_data), 32'(prev_data));
          check("hold_id", 32'(bus.out_id), 32'(prev_id));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", 32'(1), 32'(0));
          end else begin
            beat_t e;
            e = sb.pop_front();
            check("out_id", 32'(bus.out_id), 32'(e.id));
            check("out_data", 32'(bus.out_data), 32'(e.data));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_id    = bus.out_id;
      end
    end
  end

  initial begin
    int            w;
    bit            can;
    logic [N-1:0]  exp_ready;

    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1;
      d[i] = 8'(8'hA0 + i);
      l[i] = 1'b1;
    end
    drive();
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'(0));
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_out_data", 32'(bus.out_data), 32'(0));
      check("rst_out_id", 32'(bus.out_id), 32'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 600; c++) begin
      if (c < 16) begin
        // All requesters valid with fixed payloads; a short stall mid-way.
        for (int i = 0; i < N; i++) begin
          if (!v[i]) begin
            v[i] = 1'b1;
            d[i] = 8'(8'hA0 + i);
            l[i] = 1'b1;
          end
        end
        bus.out_ready = !(c >= 8 && c < 11);
      end else if (c < 580) begin
        for (int i = 0; i < N; i++) begin
          if (!v[i] && $urandom_range(0, 2) == 0) begin
            v[i] = 1'b1;
            d[i] = 8'($urandom);
            l[i] = 1'($urandom_range(0, 1));
          end
        end
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
      drive();

      @(negedge clk);
      check("out_valid", 32'(bus.out_valid), 32'(m_full));
      w         = model_winner();
      can       = !m_full || bus.out_ready;
      exp_ready = (w >= 0 && can) ? (N'(1) << w) : '0;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));

      if (w >= 0 && can) begin
        beat_t b;
        b.id   = w;
        b.data = d[w];
        sb.push_back(b);
        m_full = 1'b1;
`ifdef RR_STREAM_ARBITER_LOCK_EN
        if (!l[w]) begin
          m_locked  = 1'b1;
          m_lock_id = w;
        end else begin
          m_locked = 1'b0;
          m_ptr    = (w + 1) % N;
        end
`else
        m_ptr = (w + 1) % N;
`endif
        v[w] = 1'b0;
      end else if (bus.out_ready) begin
        m_full = 1'b0;
      end

      @(posedge clk);
      #1;
    end

    // Let the final accepted beat leave, then the scoreboard must be empty.
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    drive();
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
